// File: rtl/bitslice_serial_ctrl.sv
// bitslice_serial_ctrl: runs WIDTH-bit operations bit-serially, LSB first,
// through one external combinational 1-bit ALU slice.
// Optional feature: define BITSLICE_ZERO_FLAG_EN to add the 'zero' output.
module bitslice_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
`ifdef BITSLICE_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_k,
  input  logic             slice_y,
  input  logic             slice_cout
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
`ifdef BITSLICE_ZERO_FLAG_EN
  logic             zsticky_q;
  logic             zero_q;
`endif

  // Sequencer: operand capture, per-bit stepping and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
`ifdef BITSLICE_ZERO_FLAG_EN
      zsticky_q <= 1'b0;
      zero_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q       <= a_in;
            b_q       <= b_in;
            op_q      <= op;
            idx_q     <= '0;
            // K1 doubles as the carry-in of the LSB step.
            cy_q      <= op[1];
            result_q  <= '0;
            busy_q    <= 1'b1;
`ifdef BITSLICE_ZERO_FLAG_EN
            zsticky_q <= 1'b1;
`endif
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[idx_q] <= slice_y;
          cy_q            <= slice_cout;
`ifdef BITSLICE_ZERO_FLAG_EN
          if (slice_y) zsticky_q <= 1'b0;
`endif
          if (idx_q == IW'(WIDTH - 1)) begin
            cout_q  <= slice_cout;
`ifdef BITSLICE_ZERO_FLAG_EN
            zero_q  <= zsticky_q & ~slice_y;
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Slice drive: current bit of the latched operands while running, else idle zeros.
  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_k   = 3'b000;
    if (state_q == S_RUN) begin
      slice_a   = a_q[idx_q];
      slice_b   = b_q[idx_q];
      slice_cin = cy_q;
      slice_k   = op_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
`ifdef BITSLICE_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_bitslice_serial_ctrl.sv
// Directed bench for bitslice_serial_ctrl with a full-adder slice model, WIDTH=8.
module tb_bitslice_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a_in, b_in;
  logic       busy, done, carry_out;
  logic [7:0] result;
  logic       slice_a, slice_b, slice_cin, slice_y, slice_cout;
  logic [2:0] slice_k;
`ifdef BITSLICE_ZERO_FLAG_EN
  logic       zero;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int pulses;
  logic [7:0] sa, sb, sc;
  logic [2:0] sk_or;

  bitslice_serial_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
`ifdef BITSLICE_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_k   (slice_k),
    .slice_y   (slice_y),
    .slice_cout(slice_cout)
  );

  // Full-adder slice model
  assign slice_y    = slice_a ^ slice_b ^ slice_cin;
  assign slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op with a one-cycle start, record slice drive per RUN cycle, wait for done.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    sa = '0; sb = '0; sc = '0; sk_or = '0;
    cyc = 1;
    while (!done && cyc < 20) begin
      if (cyc <= 8) begin
        sa[3'(cyc-1)] = slice_a;
        sb[3'(cyc-1)] = slice_b;
        sc[3'(cyc-1)] = slice_cin;
        sk_or = sk_or | slice_k;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", cyc, 9);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_cout", {31'd0, carry_out}, 32'd0);
    check("rst_slice", {26'd0, slice_a, slice_b, slice_cin, slice_k}, 32'd0);
    rst = 1'b0;

    // Add: 5A + 33 = 8D, no carry
    run_op(3'b000, 8'h5A, 8'h33);
    check("add_result", {24'd0, result}, 32'h8D);
    check("add_cout", {31'd0, carry_out}, 32'd0);
`ifdef BITSLICE_ZERO_FLAG_EN
    check("add_zero", {31'd0, zero}, 32'd0);
`endif
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_clear", {31'd0, busy}, 32'd0);
    check("add_hold", {24'd0, result}, 32'h8D);

    // Initial carry from op[1]: FF + 00 + 1 = 1_00
    run_op(3'b010, 8'hFF, 8'h00);
    check("icy_first_cin", {31'd0, sc[0]}, 32'd1);
    check("icy_result", {24'd0, result}, 32'h00);
    check("icy_cout", {31'd0, carry_out}, 32'd1);
    check("icy_k", {29'd0, sk_or}, 32'd2);
`ifdef BITSLICE_ZERO_FLAG_EN
    check("icy_zero", {31'd0, zero}, 32'd1);
`endif

    // Slice sequencing, LSB first
    run_op(3'b000, 8'h01, 8'h80);
    check("seq_a", {24'd0, sa}, 32'h01);
    check("seq_b", {24'd0, sb}, 32'h80);
    check("seq_k", {29'd0, sk_or}, 32'd0);
    check("seq_result", {24'd0, result}, 32'h81);
    check("seq_cout", {31'd0, carry_out}, 32'd0);

    // Busy lockout: start held high, operands churn during the run
    @(negedge clk);
    op = 3'b000; a_in = 8'h5A; b_in = 8'h33; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 20) begin
      a_in = a_in + 8'h11; b_in = ~b_in;
      @(negedge clk);
      cyc++;
    end
    check("lock_lat1", cyc, 9);
    check("lock_res1", {24'd0, result}, 32'h8D);
    a_in = 8'h10; b_in = 8'h01;
    @(negedge clk);
    check("lock_idle_gap", {31'd0, busy}, 32'd0);
    check("lock_res1_hold", {24'd0, result}, 32'h8D);
    @(negedge clk);
    check("lock_accept2", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      a_in = a_in + 8'h11; b_in = ~b_in;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("lock_lat2", cyc, 9);
    check("lock_res2", {24'd0, result}, 32'h11);

    // Reset mid-op at idx 4
    repeat (2) @(negedge clk);
    op = 3'b000; a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_pre_result", {24'd0, result}, 32'h0F);
    check("mid_pre_a", {31'd0, slice_a}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_result", {24'd0, result}, 32'd0);
    check("mid_cout", {31'd0, carry_out}, 32'd0);
    check("mid_slice", {26'd0, slice_a, slice_b, slice_cin, slice_k}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("mid_no_done", pulses, 0);
    run_op(3'b000, 8'h7F, 8'h01);
    check("post_rst_result", {24'd0, result}, 32'h80);
    check("post_rst_cout", {31'd0, carry_out}, 32'd0);
`ifdef BITSLICE_ZERO_FLAG_EN
    check("post_rst_zero", {31'd0, zero}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
